// File: rtl/arb_pkg.sv
// Shared types and constants for the two-requester burst arbiter.
// Source codes double as the 2:1 mux select values.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCK_A,
    LOCK_B
  } state_t;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  localparam int DEF_WIDTH     = 16;
  localparam int DEF_MAX_BEATS = 16;

endpackage

// File: rtl/mux2_stream_arbiter_mux.sv
// Plain 2:1 halfword mux on the shared datapath.
// choose=0 passes a, choose=1 passes b.
module mux2_stream_arbiter_mux #(
  parameter int WIDTH = 16
) (
  input  logic             choose,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] z
);

  assign z = choose ? b : a;

endmodule

// File: rtl/mux2_stream_arbiter.sv
// Round-robin, burst-locked arbiter of two valid/ready streams
// onto one registered output stream through the shared 2:1 mux.
module mux2_stream_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic             a_last,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic             b_last,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             z_valid,
  output logic [WIDTH-1:0] z_data,
  output logic             z_last,
  output logic             z_src,
  input  logic             z_ready,
  output logic             burst_err
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  state_t          state;
  logic            prio;
  logic [CW-1:0]   cnt;
  logic            sel_q;

  logic            accept;
  logic            grant_a;
  logic            grant_b;
  logic            choose;
  logic            fire;
  logic            beat_last;
  logic            forced;
  logic            done;
  logic [CW-1:0]   cnt_nxt;
  logic [WIDTH-1:0] mux_z;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state)
      IDLE: begin
        grant_a = a_valid && (!b_valid || prio == SRC_A);
        grant_b = b_valid && (!a_valid || prio == SRC_B);
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: ;
    endcase
  end

  assign accept  = !z_valid || z_ready;
  assign a_ready = rst_n && accept && grant_a;
  assign b_ready = rst_n && accept && grant_b;

  // With no grant the select keeps pointing at the last source.
  assign choose = grant_b ? SRC_B : (grant_a ? SRC_A : sel_q);

  assign fire      = (a_valid && a_ready) || (b_valid && b_ready);
  assign beat_last = (choose == SRC_B) ? b_last : a_last;
  assign cnt_nxt   = (state == IDLE) ? CW'(1) : cnt + CW'(1);
  assign forced    = !beat_last && (cnt_nxt == CW'(MAX_BEATS));
  assign done      = beat_last || forced;

  mux2_stream_arbiter_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .choose (choose),
    .a      (a_data),
    .b      (b_data),
    .z      (mux_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= SRC_A;
      cnt       <= '0;
      sel_q     <= SRC_A;
      z_valid   <= 1'b0;
      z_data    <= '0;
      z_last    <= 1'b0;
      z_src     <= SRC_A;
      burst_err <= 1'b0;
    end else begin
      sel_q     <= choose;
      burst_err <= fire && forced;
      if (fire) begin
        z_valid <= 1'b1;
        z_data  <= mux_z;
        z_src   <= choose;
        z_last  <= done;
        if (done) begin
          state <= IDLE;
          cnt   <= '0;
          prio  <= ~choose;
        end else begin
          state <= (choose == SRC_B) ? LOCK_B : LOCK_A;
          cnt   <= cnt_nxt;
        end
      end else if (z_ready) begin
        z_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Bench for mux2_stream_arbiter: directed vector table, a reset
// mid-burst sequence, and random traffic against a burst-level model.
module tb_mux2_stream_arbiter;

  localparam int W    = 16;
  localparam int MAXB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         a_valid = 0, a_last = 0, b_valid = 0, b_last = 0;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic         z_ready = 0;
  logic         a_ready, b_ready, z_valid, z_last, z_src, burst_err;
  logic [W-1:0] z_data;

  always #5 clk = ~clk;

  mux2_stream_arbiter #(
    .WIDTH     (W),
    .MAX_BEATS (MAXB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_valid   (a_valid),
    .a_last    (a_last),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_last    (b_last),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .z_valid   (z_valid),
    .z_data    (z_data),
    .z_last    (z_last),
    .z_src     (z_src),
    .z_ready   (z_ready),
    .burst_err (burst_err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic ea, logic eb, logic ezv,
                         logic [W-1:0] ezd, logic ezs, logic ezl,
                         logic eerr);
    chk({tag, ".a_ready"}, 32'(a_ready), 32'(ea));
    chk({tag, ".b_ready"}, 32'(b_ready), 32'(eb));
    chk({tag, ".z_valid"}, 32'(z_valid), 32'(ezv));
    chk({tag, ".z_data"}, 32'(z_data), 32'(ezd));
    chk({tag, ".z_src"}, 32'(z_src), 32'(ezs));
    chk({tag, ".z_last"}, 32'(z_last), 32'(ezl));
    chk({tag, ".burst_err"}, 32'(burst_err), 32'(eerr));
  endtask

  typedef struct {
    logic         av, al;
    logic [W-1:0] ad;
    logic         bv, bl;
    logic [W-1:0] bd;
    logic         zr;
    logic         ea, eb, ezv;
    logic [W-1:0] ezd;
    logic         ezs, ezl, eerr;
  } vec_t;

  vec_t tv[30];

  function automatic vec_t mk(logic av, logic al, logic [W-1:0] ad,
                              logic bv, logic bl, logic [W-1:0] bd,
                              logic zr, logic ea, logic eb, logic ezv,
                              logic [W-1:0] ezd, logic ezs, logic ezl,
                              logic eerr);
    vec_t v;
    v.av = av; v.al = al; v.ad = ad;
    v.bv = bv; v.bl = bl; v.bd = bd;
    v.zr = zr; v.ea = ea; v.eb = eb; v.ezv = ezv;
    v.ezd = ezd; v.ezs = ezs; v.ezl = ezl; v.eerr = eerr;
    return v;
  endfunction

  // Burst-level reference model.
  int           m_owner;
  int           m_beats;
  bit           m_prio;
  bit           m_zv, m_zs, m_zl, m_err;
  logic [W-1:0] m_zd;

  task automatic m_reset();
    m_owner = -1; m_beats = 0; m_prio = 0;
    m_zv = 0; m_zs = 0; m_zl = 0; m_err = 0; m_zd = '0;
  endtask

  task automatic m_take(int s, bit l, logic [W-1:0] d);
    bit f;
    m_beats++;
    f = !l && (m_beats == MAXB);
    m_zv = 1; m_zd = d; m_zs = (s == 1); m_zl = l || f; m_err = f;
    if (l || f) begin
      m_owner = -1; m_beats = 0; m_prio = (s == 0);
    end else begin
      m_owner = s;
    end
  endtask

  initial begin
    bit acc, ga, gb, era, erb;

    tv[0]  = mk(1,1,16'hAAAA,1,1,16'hBBBB,1, 1,0,0,16'h0000,0,0,0);
    tv[1]  = mk(1,1,16'hAAAA,1,1,16'hBBBB,1, 0,1,1,16'hAAAA,0,1,0);
    tv[2]  = mk(1,1,16'hAAAA,1,1,16'hBBBB,1, 1,0,1,16'hBBBB,1,1,0);
    tv[3]  = mk(1,1,16'hAAAA,1,1,16'hBBBB,1, 0,1,1,16'hAAAA,0,1,0);
    tv[4]  = mk(1,0,16'h1111,0,0,16'h0000,1, 1,0,1,16'hBBBB,1,1,0);
    tv[5]  = mk(1,0,16'h2222,0,0,16'h0000,1, 1,0,1,16'h1111,0,0,0);
    tv[6]  = mk(1,1,16'h3333,0,0,16'h0000,1, 1,0,1,16'h2222,0,0,0);
    tv[7]  = mk(1,0,16'h4001,0,0,16'h0000,1, 1,0,1,16'h3333,0,1,0);
    tv[8]  = mk(1,0,16'h4002,1,1,16'hB001,1, 1,0,1,16'h4001,0,0,0);
    tv[9]  = mk(0,0,16'h0000,1,1,16'hB001,1, 1,0,1,16'h4002,0,0,0);
    tv[10] = mk(0,0,16'h0000,1,1,16'hB001,1, 1,0,0,16'h4002,0,0,0);
    tv[11] = mk(0,0,16'h0000,1,1,16'hB001,1, 1,0,0,16'h4002,0,0,0);
    tv[12] = mk(1,1,16'h4003,1,1,16'hB001,1, 1,0,0,16'h4002,0,0,0);
    tv[13] = mk(0,0,16'h0000,1,1,16'hB001,1, 0,1,1,16'h4003,0,1,0);
    tv[14] = mk(1,1,16'h1234,0,0,16'h0000,1, 1,0,1,16'hB001,1,1,0);
    for (int i = 15; i < 20; i++)
      tv[i] = mk(1,1,16'h5678,0,0,16'h0000,0, 0,0,1,16'h1234,0,1,0);
    tv[20] = mk(1,1,16'h5678,0,0,16'h0000,1, 1,0,1,16'h1234,0,1,0);
    tv[21] = mk(0,0,16'h0000,0,0,16'h0000,1, 0,0,1,16'h5678,0,1,0);
    tv[22] = mk(1,0,16'h6001,0,0,16'h0000,1, 1,0,0,16'h5678,0,1,0);
    tv[23] = mk(1,0,16'h6002,1,1,16'hC001,1, 1,0,1,16'h6001,0,0,0);
    tv[24] = mk(1,0,16'h6003,1,1,16'hC001,1, 1,0,1,16'h6002,0,0,0);
    tv[25] = mk(1,0,16'h6004,1,1,16'hC001,1, 1,0,1,16'h6003,0,0,0);
    tv[26] = mk(1,0,16'h6005,1,1,16'hC001,1, 0,1,1,16'h6004,0,1,1);
    tv[27] = mk(1,0,16'h6005,0,0,16'h0000,1, 1,0,1,16'hC001,1,1,0);
    tv[28] = mk(1,1,16'h6006,0,0,16'h0000,1, 1,0,1,16'h6005,0,0,0);
    tv[29] = mk(0,0,16'h0000,0,0,16'h0000,1, 0,0,1,16'h6006,0,1,0);

    // Reset values, with requests pending during reset.
    a_valid = 1; b_valid = 1; z_ready = 1;
    #3;
    chk_all("rst", 0, 0, 0, 16'h0000, 0, 0, 0);
    a_valid = 0; b_valid = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Directed vector table.
    for (int i = 0; i < 30; i++) begin
      a_valid = tv[i].av; a_last = tv[i].al; a_data = tv[i].ad;
      b_valid = tv[i].bv; b_last = tv[i].bl; b_data = tv[i].bd;
      z_ready = tv[i].zr;
      @(negedge clk);
      chk_all($sformatf("v%0d", i), tv[i].ea, tv[i].eb, tv[i].ezv,
              tv[i].ezd, tv[i].ezs, tv[i].ezl, tv[i].eerr);
      @(posedge clk);
      #1;
    end

    // Reset in the middle of a B burst (LOCK_B, two beats taken).
    a_valid = 0; b_valid = 1; b_last = 0; b_data = 16'h7001; z_ready = 1;
    @(negedge clk);
    chk("mb.b_ready0", 32'(b_ready), 1);
    @(posedge clk);
    #1;
    b_data = 16'h7002;
    @(negedge clk);
    chk("mb.b_ready1", 32'(b_ready), 1);
    chk("mb.z_data1", 32'(z_data), 32'h7001);
    @(posedge clk);
    #1;
    a_valid = 1; a_last = 1; a_data = 16'h8001;
    b_valid = 1; b_last = 1; b_data = 16'h8002;
    #1;
    rst_n = 0;
    #1;
    chk("mb.rst_z_valid", 32'(z_valid), 0);
    chk("mb.rst_z_data", 32'(z_data), 0);
    chk("mb.rst_a_ready", 32'(a_ready), 0);
    chk("mb.rst_b_ready", 32'(b_ready), 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("mb.post_a_ready", 32'(a_ready), 1);
    chk("mb.post_b_ready", 32'(b_ready), 0);
    @(posedge clk);
    #1;
    a_valid = 0; b_valid = 0;
    @(negedge clk);
    chk("mb.post_z_data", 32'(z_data), 32'h8001);
    chk("mb.post_z_src", 32'(z_src), 0);

    // Random traffic against the model.
    @(posedge clk);
    #1;
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    m_reset();
    @(posedge clk);
    #1;
    for (int c = 0; c < 3000; c++) begin
      a_valid = ($urandom_range(0, 3) != 0);
      a_last  = ($urandom_range(0, 3) == 0);
      a_data  = W'($urandom);
      b_valid = ($urandom_range(0, 3) != 0);
      b_last  = ($urandom_range(0, 3) == 0);
      b_data  = W'($urandom);
      z_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = !m_zv || z_ready;
      if (m_owner < 0) begin
        ga = a_valid && (!b_valid || !m_prio);
        gb = b_valid && (!a_valid || m_prio);
      end else begin
        ga = (m_owner == 0);
        gb = (m_owner == 1);
      end
      era = acc && ga;
      erb = acc && gb;
      chk_all($sformatf("rnd%0d", c), era, erb, m_zv, m_zd, m_zs, m_zl,
              m_err);
      m_err = 0;
      if (era && a_valid)      m_take(0, a_last, a_data);
      else if (erb && b_valid) m_take(1, b_last, b_data);
      else if (z_ready)        m_zv = 0;
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
